// File: rtl/recursive_mult_err_monitor.sv
// Error monitor for an 8x8 approximate multiplier: accumulates |a*b - Y| over a window of SAMPLE_CNT samples.
// Optional MAX_ERR_TRACK_EN adds max_err / max_a / max_b tracking.
module recursive_mult_err_monitor #(
  parameter int SAMPLE_CNT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] Y,
  output logic        busy,
  output logic        done,
  output logic [31:0] err_sum,
  output logic [15:0] err_cnt,
  output logic [15:0] sample_cnt
`ifdef MAX_ERR_TRACK_EN
  ,
  output logic [15:0] max_err,
  output logic [7:0]  max_a,
  output logic [7:0]  max_b
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state, stateNxt;
  logic [2:1]  vldPipe;
  logic        accept, clearWin, lastAccept;
  logic [7:0]  s1A, s1B;
  logic [15:0] s1Y, s1Prod, absErr;

  assign in_ready   = (state == RUN);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign clearWin   = start & ((state == IDLE) || (state == DONE));
  assign lastAccept = accept && (sample_cnt == 16'(SAMPLE_CNT - 1));
  assign absErr     = (s1Prod >= s1Y) ? (s1Prod - s1Y) : (s1Y - s1Prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // DRAIN ends once the last sample has left stage 1 and sits in stage 2,
  // which is always exactly two cycles after the final acceptance.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE, DONE: if (start) stateNxt = RUN;
      RUN:        if (lastAccept) stateNxt = DRAIN;
      DRAIN:      if (vldPipe[2] && !vldPipe[1]) stateNxt = DONE;
      default:    stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vldPipe    <= '0;
      s1A        <= '0;
      s1B        <= '0;
      s1Y        <= '0;
      s1Prod     <= '0;
      err_sum    <= '0;
      err_cnt    <= '0;
      sample_cnt <= '0;
`ifdef MAX_ERR_TRACK_EN
      max_err    <= '0;
      max_a      <= '0;
      max_b      <= '0;
`endif
    end else begin
      vldPipe <= {vldPipe[1], accept};
      if (accept) begin
        s1A    <= a;
        s1B    <= b;
        s1Y    <= Y;
        s1Prod <= 16'(a) * 16'(b);
      end
      if (clearWin) begin
        err_sum    <= '0;
        err_cnt    <= '0;
        sample_cnt <= '0;
`ifdef MAX_ERR_TRACK_EN
        max_err    <= '0;
        max_a      <= '0;
        max_b      <= '0;
`endif
      end else begin
        if (accept) sample_cnt <= sample_cnt + 16'd1;
        if (vldPipe[1]) begin
          err_sum <= err_sum + {16'd0, absErr};
          if (absErr != 16'd0) err_cnt <= err_cnt + 16'd1;
`ifdef MAX_ERR_TRACK_EN
          // strict compare: ties keep the earlier sample's operands
          if (absErr > max_err) begin
            max_err <= absErr;
            max_a   <= s1A;
            max_b   <= s1B;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_recursive_mult_err_monitor.sv
// Randomized bench for recursive_mult_err_monitor (SAMPLE_CNT=4) with a window-level reference model.
// Build with MAX_ERR_TRACK_EN to also check the max tracking ports.
module tb_recursive_mult_err_monitor;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, busy, done;
  logic [7:0]  a, b;
  logic [15:0] Y, err_cnt, sample_cnt;
  logic [31:0] err_sum;
`ifdef MAX_ERR_TRACK_EN
  logic [15:0] max_err;
  logic [7:0]  max_a, max_b;
`endif

  int total = 0, bad = 0;
  int mSum, mCnt, mN, mMax, mA, mB;

  recursive_mult_err_monitor #(.SAMPLE_CNT(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .Y(Y), .busy(busy), .done(done),
    .err_sum(err_sum), .err_cnt(err_cnt), .sample_cnt(sample_cnt)
`ifdef MAX_ERR_TRACK_EN
    , .max_err(max_err), .max_a(max_a), .max_b(max_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic modelClear();
    mSum = 0; mCnt = 0; mN = 0; mMax = 0; mA = 0; mB = 0;
  endtask

  task automatic modelAdd(input int ai, input int bi, input int yi);
    int e, d;
    e = ai * bi;
    d = (e > yi) ? e - yi : yi - e;
    mSum += d;
    if (d != 0) mCnt++;
    mN++;
    if (d > mMax) begin mMax = d; mA = ai; mB = bi; end
  endtask

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic openWin();
    start = 1'b1; modelClear(); tick(); start = 1'b0;
  endtask

  task automatic drive(input int ai, input int bi, input int yi);
    a = 8'(ai); b = 8'(bi); Y = 16'(yi); in_valid = 1'b1;
    if (in_ready) modelAdd(ai, bi, yi);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic driveRand();
    int ai, bi, yi;
    ai = $urandom_range(0, 255); bi = $urandom_range(0, 255);
    case ($urandom_range(0, 2))
      0: yi = ai * bi;
      1: begin
        yi = ai * bi + $urandom_range(0, 8) - 4;
        if (yi < 0 || yi > 65535) yi = ai * bi;
      end
      default: yi = $urandom_range(0, 65535);
    endcase
    drive(ai, bi, yi);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    total++;
    if ({in_ready, busy, done, err_sum, err_cnt, sample_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs got rdy=%0b busy=%0b done=%0b sum=%0d cnt=%0d n=%0d want all 0",
                      in_ready, busy, done, err_sum, err_cnt, sample_cnt);
    end
    rst = 1'b0; in_valid = 1'b1; a = 8'd9; b = 8'd9; Y = 16'd0;
    tick(); tick(); tick();
    total++;
    if ({in_ready, busy, done, err_sum, err_cnt, sample_cnt} !== '0) begin
      bad++; $display("FAIL idle_ignores_valid got rdy=%0b busy=%0b sum=%0d n=%0d want all 0",
                      in_ready, busy, err_sum, sample_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_all_wrong();
    openWin();
    drive(1, 1, 0);
    total++;
    if (err_sum !== 32'd0) begin bad++; $display("FAIL latency_early got %0d want 0", err_sum); end
    drive(1, 1, 0);
    total++;
    if (err_sum !== 32'd1) begin bad++; $display("FAIL latency_two got %0d want 1", err_sum); end
    drive(1, 1, 0);
    drive(1, 1, 0);
    total++;
    if ({done, busy, in_ready, sample_cnt} !== {1'b0, 1'b1, 1'b0, 16'd4}) begin
      bad++; $display("FAIL drain1 got done=%0b busy=%0b rdy=%0b n=%0d want 0 1 0 4", done, busy, in_ready, sample_cnt);
    end
    tick();
    total++;
    if ({done, busy, err_sum} !== {1'b0, 1'b1, 32'd4}) begin
      bad++; $display("FAIL drain2 got done=%0b busy=%0b sum=%0d want 0 1 4", done, busy, err_sum);
    end
    tick();
    total++;
    if ({done, busy, err_sum, err_cnt, sample_cnt} !== {1'b1, 1'b0, 32'd4, 16'd4, 16'd4}) begin
      bad++; $display("FAIL all_wrong_done got done=%0b busy=%0b sum=%0d cnt=%0d n=%0d want 1 0 4 4 4",
                      done, busy, err_sum, err_cnt, sample_cnt);
    end
  endtask

  task automatic test_exact();
    int ai, bi;
    openWin();
    drive(3, 3, 9);
    drive(255, 255, 65025);
    for (int i = 0; i < 2; i++) begin
      ai = $urandom_range(0, 255); bi = $urandom_range(0, 255);
      drive(ai, bi, ai * bi);
    end
    waitDone();
    total++;
    if ({done, err_sum, err_cnt, sample_cnt} !== {1'b1, 32'd0, 16'd0, 16'd4}) begin
      bad++; $display("FAIL exact got done=%0b sum=%0d cnt=%0d n=%0d want 1 0 0 4", done, err_sum, err_cnt, sample_cnt);
    end
  endtask

  task automatic test_max();
    openWin();
    drive(2, 2, 6);
    drive(2, 2, 2);
    drive(5, 5, 20);
    drive(7, 3, 21);
    waitDone();
    total++;
    if ({done, err_sum, err_cnt} !== {1'b1, 32'd9, 16'd3}) begin
      bad++; $display("FAIL max_sum got done=%0b sum=%0d cnt=%0d want 1 9 3", done, err_sum, err_cnt);
    end
`ifdef MAX_ERR_TRACK_EN
    total++;
    if ({max_err, max_a, max_b} !== {16'd5, 8'd5, 8'd5}) begin
      bad++; $display("FAIL max_track got %0d/%0d/%0d want 5/5/5", max_err, max_a, max_b);
    end
`endif
  endtask

  task automatic test_toggle();
    openWin();
    for (int i = 0; i < 16 && mN < N; i++) begin
      a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); Y = 16'($urandom_range(0, 65535));
      in_valid = (i % 2) == 1;
      if (in_valid && in_ready) modelAdd(int'(a), int'(b), int'(Y));
      tick();
    end
    in_valid = 1'b0;
    waitDone();
    total++;
    if ({done, sample_cnt, err_sum, err_cnt} !== {1'b1, 16'd4, 32'(mSum), 16'(mCnt)}) begin
      bad++; $display("FAIL toggle got done=%0b n=%0d sum=%0d cnt=%0d want 1 4 %0d %0d",
                      done, sample_cnt, err_sum, err_cnt, mSum, mCnt);
    end
    in_valid = 1'b1; a = 8'd200; b = 8'd200; Y = 16'd0;
    tick(); tick(); tick();
    in_valid = 1'b0;
    total++;
    if ({done, sample_cnt, err_sum, err_cnt} !== {1'b1, 16'd4, 32'(mSum), 16'(mCnt)}) begin
      bad++; $display("FAIL done_hold got done=%0b n=%0d sum=%0d cnt=%0d want 1 4 %0d %0d",
                      done, sample_cnt, err_sum, err_cnt, mSum, mCnt);
    end
  endtask

  task automatic test_reset_mid();
    openWin();
    drive(1, 1, 0);
    drive(1, 1, 0);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, busy, done, err_sum, err_cnt, sample_cnt} !== '0) begin
      bad++; $display("FAIL reset_mid got rdy=%0b busy=%0b done=%0b sum=%0d cnt=%0d n=%0d want all 0",
                      in_ready, busy, done, err_sum, err_cnt, sample_cnt);
    end
`ifdef MAX_ERR_TRACK_EN
    total++;
    if ({max_err, max_a, max_b} !== '0) begin
      bad++; $display("FAIL reset_mid_max got %0d/%0d/%0d want 0", max_err, max_a, max_b);
    end
`endif
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    total++;
    if ({in_ready, busy, done, err_sum, sample_cnt} !== '0) begin
      bad++; $display("FAIL post_reset_idle got rdy=%0b busy=%0b done=%0b sum=%0d n=%0d want all 0",
                      in_ready, busy, done, err_sum, sample_cnt);
    end
    openWin();
    for (int i = 0; i < N; i++) driveRand();
    waitDone();
    total++;
    if ({done, sample_cnt, err_sum, err_cnt} !== {1'b1, 16'd4, 32'(mSum), 16'(mCnt)}) begin
      bad++; $display("FAIL clean_window got done=%0b n=%0d sum=%0d cnt=%0d want 1 4 %0d %0d",
                      done, sample_cnt, err_sum, err_cnt, mSum, mCnt);
    end
  endtask

  task automatic test_start_ignored();
    openWin();
    driveRand();
    driveRand();
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if ({busy, sample_cnt} !== {1'b1, 16'd2}) begin
      bad++; $display("FAIL start_in_run got busy=%0b n=%0d want 1 2", busy, sample_cnt);
    end
    driveRand();
    driveRand();
    waitDone();
    total++;
    if ({done, sample_cnt, err_sum, err_cnt} !== {1'b1, 16'd4, 32'(mSum), 16'(mCnt)}) begin
      bad++; $display("FAIL after_ignored got done=%0b n=%0d sum=%0d cnt=%0d want 1 4 %0d %0d",
                      done, sample_cnt, err_sum, err_cnt, mSum, mCnt);
    end
    openWin();
    total++;
    if ({done, busy, err_sum, err_cnt, sample_cnt} !== {1'b0, 1'b1, 32'd0, 16'd0, 16'd0}) begin
      bad++; $display("FAIL start_in_done got done=%0b busy=%0b sum=%0d cnt=%0d n=%0d want 0 1 0 0 0",
                      done, busy, err_sum, err_cnt, sample_cnt);
    end
    for (int i = 0; i < N; i++) driveRand();
    waitDone();
    total++;
    if ({done, err_sum, err_cnt} !== {1'b1, 32'(mSum), 16'(mCnt)}) begin
      bad++; $display("FAIL restart_window got done=%0b sum=%0d cnt=%0d want 1 %0d %0d", done, err_sum, err_cnt, mSum, mCnt);
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 4; w++) begin
      openWin();
      for (int i = 0; i < 60 && mN < N; i++) begin
        if ($urandom_range(0, 1) == 1) driveRand();
        else tick();
      end
      waitDone();
      total++;
      if ({done, sample_cnt, err_sum, err_cnt} !== {1'b1, 16'd4, 32'(mSum), 16'(mCnt)}) begin
        bad++; $display("FAIL random_w%0d got done=%0b n=%0d sum=%0d cnt=%0d want 1 4 %0d %0d",
                        w, done, sample_cnt, err_sum, err_cnt, mSum, mCnt);
      end
`ifdef MAX_ERR_TRACK_EN
      total++;
      if ({max_err, max_a, max_b} !== {16'(mMax), 8'(mA), 8'(mB)}) begin
        bad++; $display("FAIL random_max_w%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                        w, max_err, max_a, max_b, mMax, mA, mB);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; Y = '0;
    modelClear();
    @(negedge clk);
    test_reset();
    test_all_wrong();
    test_exact();
    test_max();
    test_toggle();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/recursive_mult_err_monitor.md
RECURSIVE_MULT_ERR_MONITOR -- requirements
Module: recursive_mult_err_monitor

Interface
REQ-001 SHALL have parameter SAMPLE_CNT, default 256, meaning the number of samples per measurement window (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1, meaning "begin a new window"; sampled each cycle.
REQ-005 SHALL have port in_valid, input, 1, meaning sample present on a/b/Y.
REQ-006 SHALL have port in_ready, output, 1, meaning the monitor accepts a sample this cycle.
REQ-007 SHALL have ports a and b, input, 8 each, the unsigned operands fed to the upstream 8x8 approximate recursive multiplier.
REQ-008 SHALL have port Y, input, 16, the multiplier's approximate product for a, b.
REQ-009 SHALL have port busy, output, 1, meaning the state is RUN or DRAIN.
REQ-010 SHALL have port done, output, 1, a level meaning window results are valid.
REQ-011 SHALL have port err_sum, output, 32, the sum of |a*b - Y| over the window.
REQ-012 SHALL have port err_cnt, output, 16, the count of samples with Y != a*b.
REQ-013 SHALL have port sample_cnt, output, 16, the number of accepted samples in the current window.
REQ-014 SHALL have ports max_err (16 bits), max_a (8 bits) and max_b (8 bits), all outputs, present only under MAX_ERR_TRACK_EN.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-016 SHALL, in IDLE or DONE, move to RUN on start=1 and clear err_sum, err_cnt, sample_cnt, max_* and done in that same edge.
REQ-017 SHALL drive in_ready=1 only in RUN; a sample is accepted when in_valid & in_ready.
REQ-018 SHALL, on acceptance, increment sample_cnt; when the acceptance makes sample_cnt equal SAMPLE_CNT, next state is DRAIN.
REQ-019 SHALL use a two-stage pipeline.
- Stage 1 registers a, b, Y and the exact product a*b (16 bits).
- Stage 2 computes the 16-bit |exact - Y| and updates the accumulators.
REQ-020 SHALL reflect an accepted sample in err_sum, err_cnt and max_* exactly 2 cycles after acceptance.
REQ-021 SHALL stay in DRAIN for exactly 2 cycles, then enter DONE with done=1; all results hold until the next start.
REQ-022 SHALL ignore start while in RUN or DRAIN.
REQ-023 SHALL size err_sum so that no overflow is possible (65535*65535 < 2^32); no saturation logic is required.
REQ-024 SHALL treat Y > a*b symmetrically, as absolute error.
REQ-025 SHALL hold the accumulators unchanged in cycles with no acceptance, even when in_valid=1 outside RUN.

Reset
REQ-026 SHALL, on rst=1, asynchronously force state IDLE, clear both pipeline stages' valid bits, and set every output to 0 (in_ready=0, busy=0, done=0).
REQ-027 SHALL abandon any in-flight window if rst asserts mid-RUN or mid-DRAIN; no partial result is reported after rst deasserts.

Configuration
REQ-028 SHALL, with macro MAX_ERR_TRACK_EN defined, track max_err and the a/b of the first sample achieving it.
- The update uses a strict greater-than comparison, so ties keep the earlier sample.
REQ-029 SHALL, without MAX_ERR_TRACK_EN, omit the max_err, max_a and max_b ports and their comparison logic; all other behaviour is identical.

Verification
REQ-030 SHALL cover: SAMPLE_CNT=4, start, then four samples (a,b,Y)=(1,1,0) -> done=1 two cycles after the 4th acceptance (DRAIN), err_sum=4, err_cnt=4, sample_cnt=4.
REQ-031 SHALL cover: samples (3,3,9),(255,255,65025) -> err_sum=0, err_cnt=0.
REQ-032 SHALL cover: samples (2,2,6),(2,2,2),(5,5,20) with MAX_ERR_TRACK_EN -> err_sum=9, max_err=5, max_a=5, max_b=5.
REQ-033 SHALL cover: in_valid toggling every other cycle during RUN -> only handshaked samples are counted, and sample_cnt reaches SAMPLE_CNT exactly.
REQ-034 SHALL cover: rst pulse after 2 of 4 samples -> all outputs 0 and state IDLE; a new start then yields a clean window.
REQ-035 SHALL cover: start asserted in RUN -> ignored; start asserted in DONE -> done=0 and counters cleared on the next edge.
